// File: rtl/axis_agent_pkg.sv
// Shared types and sizing helpers for the AXI4-Stream beat agent.
// The beat struct is sized for the default one-byte stream.
package axis_agent_pkg;

    localparam int DEF_W     = 8;
    localparam int DEF_DEPTH = 4;

    // Occupancy must represent 0..depth inclusive, hence the extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int CNT_W = cnt_width(DEF_DEPTH);

    typedef struct packed {
        logic [DEF_W-1:0] data;
        logic             last;
    } beat_t;

endpackage

// File: rtl/axis_beat_fifo.sv
// Synchronous valid/ready FIFO with registered ready, valid and head beat.
// No bypass: a beat written into an empty FIFO shows up one cycle later.
module axis_beat_fifo
    import axis_agent_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    input  logic         in_last_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o,
    output logic         out_last_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [W:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rdy_q, vld_q;
    logic [W:0]    head_q, head_d;
    logic          wr, rd;

    always_comb begin
        wr       = in_valid_i & rdy_q;
        rd       = out_ready_i & vld_q;
        wr_ptr_d = wr_ptr_q + AW'(wr);
        rd_ptr_d = rd_ptr_q + AW'(rd);
        cnt_d    = cnt_q + CW'(wr) - CW'(rd);
        head_d   = '0;
        // The new head may be the slot being written this very cycle.
        if (cnt_d != '0) begin
            if (wr && (rd_ptr_d == wr_ptr_q))
                head_d = {in_last_i, in_data_i};
            else
                head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr)
            mem_q[wr_ptr_q] <= {in_last_i, in_data_i};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
            vld_q    <= 1'b0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rdy_q    <= (cnt_d != CW'(DEPTH));
            vld_q    <= (cnt_d != '0);
            head_q   <= head_d;
        end
    end

    assign in_ready_o  = rdy_q;
    assign out_valid_o = vld_q;
    assign out_data_o  = head_q[W-1:0];
    assign out_last_o  = head_q[W];

endmodule

// File: rtl/axis_beat_agent.sv
// AXI4-Stream beat agent: local push port -> TX FIFO -> AXIS master,
// AXIS slave -> RX FIFO -> local pop port.
module axis_beat_agent
    import axis_agent_pkg::*;
#(
    parameter int TDATA_BYTES = 1,
    parameter int DEPTH       = 4,
    localparam int W          = 8 * TDATA_BYTES
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         put_valid,
    output logic         put_ready,
    input  logic [W-1:0] put_data,
    input  logic         put_last,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic [W-1:0] m_axis_tdata,
    output logic         m_axis_tlast,
    input  logic         s_axis_tvalid,
    output logic         s_axis_tready,
    input  logic [W-1:0] s_axis_tdata,
    input  logic         s_axis_tlast,
    output logic         get_valid,
    input  logic         get_ready,
    output logic [W-1:0] get_data,
    output logic         get_last
);

    axis_beat_fifo #(.W(W), .DEPTH(DEPTH)) u_tx (
        .clk_i       (aclk),
        .rst_n_i     (aresetn),
        .in_valid_i  (put_valid),
        .in_ready_o  (put_ready),
        .in_data_i   (put_data),
        .in_last_i   (put_last),
        .out_valid_o (m_axis_tvalid),
        .out_ready_i (m_axis_tready),
        .out_data_o  (m_axis_tdata),
        .out_last_o  (m_axis_tlast)
    );

    axis_beat_fifo #(.W(W), .DEPTH(DEPTH)) u_rx (
        .clk_i       (aclk),
        .rst_n_i     (aresetn),
        .in_valid_i  (s_axis_tvalid),
        .in_ready_o  (s_axis_tready),
        .in_data_i   (s_axis_tdata),
        .in_last_i   (s_axis_tlast),
        .out_valid_o (get_valid),
        .out_ready_i (get_ready),
        .out_data_o  (get_data),
        .out_last_o  (get_last)
    );

endmodule

// File: tb/tb_axis_beat_agent.sv
// Bench for axis_beat_agent: directed scenarios then random traffic,
// checked every cycle against a queue-based model of both paths.
module tb_axis_beat_agent;
    import axis_agent_pkg::*;

    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         put_valid, put_last, put_ready;
    logic [W-1:0] put_data;
    logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [W-1:0] m_axis_tdata;
    logic         s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [W-1:0] s_axis_tdata;
    logic         get_valid, get_ready, get_last;
    logic [W-1:0] get_data;

    int checks = 0;
    int errors = 0;

    beat_t txq[$];
    beat_t rxq[$];
    bit    rdy_en = 1'b0;

    always #5 aclk = ~aclk;

    axis_beat_agent #(.TDATA_BYTES(1), .DEPTH(DEPTH)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .put_valid     (put_valid),
        .put_ready     (put_ready),
        .put_data      (put_data),
        .put_last      (put_last),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .get_valid     (get_valid),
        .get_ready     (get_ready),
        .get_data      (get_data),
        .get_last      (get_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs with the model mid-cycle, then advance the model
    // by whatever handshakes the model says happen at the coming edge.
    task automatic step();
        bit    tx_push, tx_xfer, rx_xfer, rx_pop;
        beat_t nb;
        @(negedge aclk);
        chk("put_ready", put_ready, rdy_en && txq.size() < DEPTH);
        chk("s_tready", s_axis_tready, rdy_en && rxq.size() < DEPTH);
        chk("m_tvalid", m_axis_tvalid, txq.size() != 0);
        chk("m_tdata", m_axis_tdata, txq.size() != 0 ? txq[0].data : '0);
        chk("m_tlast", m_axis_tlast, txq.size() != 0 ? txq[0].last : 1'b0);
        chk("get_valid", get_valid, rxq.size() != 0);
        chk("get_data", get_data, rxq.size() != 0 ? rxq[0].data : '0);
        chk("get_last", get_last, rxq.size() != 0 ? rxq[0].last : 1'b0);
        tx_push = put_valid && rdy_en && txq.size() < DEPTH;
        tx_xfer = m_axis_tready && txq.size() != 0;
        rx_xfer = s_axis_tvalid && rdy_en && rxq.size() < DEPTH;
        rx_pop  = get_ready && rxq.size() != 0;
        @(posedge aclk);
        if (!aresetn) begin
            txq.delete();
            rxq.delete();
            rdy_en = 1'b0;
        end else begin
            if (tx_xfer) void'(txq.pop_front());
            if (tx_push) begin nb.data = put_data; nb.last = put_last; txq.push_back(nb); end
            if (rx_pop) void'(rxq.pop_front());
            if (rx_xfer) begin nb.data = s_axis_tdata; nb.last = s_axis_tlast; rxq.push_back(nb); end
            rdy_en = 1'b1;
        end
        #1;
    endtask

    task automatic put(input logic v, input logic [W-1:0] d, input logic l);
        put_valid = v; put_data = d; put_last = l;
    endtask

    task automatic sput(input logic v, input logic [W-1:0] d, input logic l);
        s_axis_tvalid = v; s_axis_tdata = d; s_axis_tlast = l;
    endtask

    initial begin
        aresetn = 1'b0;
        put(1'b0, '0, 1'b0);
        sput(1'b0, '0, 1'b0);
        m_axis_tready = 1'b0;
        get_ready     = 1'b0;
        @(posedge aclk); #1;
        step();

        // Release: readies rise on the first edge with aresetn high.
        aresetn = 1'b1;
        step();
        chk("rel_put_ready", put_ready, 1'b1);

        // TX pass-through with a one-cycle push-to-valid latency.
        m_axis_tready = 1'b1;
        put(1'b1, 8'h37, 1'b0); step();
        chk("tp1_first", m_axis_tdata, 8'h37);
        put(1'b1, 8'h48, 1'b0); step();
        chk("tp1_second", m_axis_tdata, 8'h48);
        put(1'b1, 8'h59, 1'b1); step();
        chk("tp1_last", {m_axis_tlast, m_axis_tdata}, 9'h159);
        put(1'b0, '0, 1'b0); step(); step();

        // RX fill with the pop side stalled, then drain.
        sput(1'b1, 8'hC8, 1'b0); step();
        sput(1'b1, 8'hB7, 1'b0); step();
        sput(1'b1, 8'hA6, 1'b1); step();
        sput(1'b0, '0, 1'b0); step();
        chk("tp2_head", {get_valid, get_data}, 9'h1C8);
        get_ready = 1'b1;
        step(); step(); step(); step();
        get_ready = 1'b0;

        // TX backpressure: DEPTH+1 pushes, the last one held off.
        m_axis_tready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            put(1'b1, 8'h10 + 8'(i), (i == DEPTH)); step();
        end
        chk("tp3_full", put_ready, 1'b0);
        chk("tp3_hold", m_axis_tdata, 8'h10);
        // Full with transfer and push offered together: only the transfer happens.
        m_axis_tready = 1'b1; step();
        chk("tp4_ready", put_ready, 1'b1);
        chk("tp4_head", m_axis_tdata, 8'h11);
        put(1'b0, '0, 1'b0);
        for (int i = 0; i < 6; i++) step();

        // Reset mid-operation with both FIFOs partly filled.
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(1'b1, 8'hE0 + 8'(i), (i == 2));
            sput(i < 2, 8'h70 + 8'(i), 1'b0);
            step();
        end
        put(1'b0, '0, 1'b0); sput(1'b0, '0, 1'b0);
        aresetn = 1'b0; step();
        chk("tp5_rst_outs", {put_ready, s_axis_tready, m_axis_tvalid, get_valid,
                             m_axis_tdata, m_axis_tlast, get_data, get_last}, '0);
        aresetn = 1'b1; m_axis_tready = 1'b1; get_ready = 1'b1; step();
        chk("tp5_rel", {put_ready, s_axis_tready, m_axis_tvalid, get_valid}, 4'b1100);
        step();

        // Random traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            aresetn       = ($urandom_range(0, 63) != 0);
            put($urandom_range(0, 2) != 0, W'($urandom), 1'($urandom));
            sput($urandom_range(0, 2) != 0, W'($urandom), 1'($urandom));
            m_axis_tready = ($urandom_range(0, 3) != 0);
            get_ready     = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
